// File: rtl/cordic_pkg.sv
// Shared constants and word layout for the CORDIC datapath (quadrant map and rotation stages).
// Angles are Q3.29 radians, x/y are Q2.30.
package cordic_pkg;

    localparam int WORD_W = 32;
    localparam int BUF_W  = 3 * WORD_W + 1;

    localparam logic signed [WORD_W-1:0] PI      = 32'sh6487ED51;
    localparam logic signed [WORD_W-1:0] PI_2    = 32'sh3243F6A9;
    localparam logic        [WORD_W-1:0] K_GAIN  = 32'h26DD3B6B;
    localparam logic        [WORD_W-1:0] ONE_Q30 = 32'h40000000;

    // Field order matches the 97-bit buffer word {neg, z, y, x}.
    typedef struct packed {
        logic              neg;
        logic [WORD_W-1:0] z;
        logic [WORD_W-1:0] y;
        logic [WORD_W-1:0] x;
    } cordic_word_t;

    typedef enum logic [1:0] {
        FOLD_NONE = 2'd0,
        FOLD_SUB  = 2'd1,
        FOLD_ADD  = 2'd2
    } fold_e;

    function automatic fold_e fold_kind(input logic signed [WORD_W-1:0] angle);
        fold_e kind;
        kind = FOLD_NONE;
        if (angle > PI_2) begin
            kind = FOLD_SUB;
        end else if (angle < -PI_2) begin
            kind = FOLD_ADD;
        end
        return kind;
    endfunction

endpackage

// File: rtl/cordic_skid_buf.sv
// Two-entry FIFO skid buffer with a registered in_ready; outputs come straight from storage.
module cordic_skid_buf #(
    parameter int WIDTH = 97
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] mem [2];
    logic             wrPtr;
    logic             rdPtr;
    logic [1:0]       count;
    logic [1:0]       countNext;
    logic             push;
    logic             pop;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rdPtr];

    always_comb begin
        countNext = count;
        case ({push, pop})
            2'b10:   countNext = count + 2'd1;
            2'b01:   countNext = count - 2'd1;
            default: countNext = count;
        endcase
    end

    // in_ready is registered from the next occupancy so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= 2'd0;
            wrPtr    <= 1'b0;
            rdPtr    <= 1'b0;
            in_ready <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
        end else begin
            if (push) begin
                mem[wrPtr] <= in_data;
                wrPtr      <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            count    <= countNext;
            in_ready <= (countNext < 2'd2);
        end
    end

endmodule

// File: rtl/cordic_quadrant_map.sv
// Folds an angle into [-pi/2, pi/2] and emits the initial CORDIC vector through a skid buffer.
// Define CORDIC_GAIN_PRELOAD_EN to preload x with the CORDIC gain K instead of 1.0.
module cordic_quadrant_map
    import cordic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] angle_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] x_out,
    output logic [WORD_W-1:0] y_out,
    output logic [WORD_W-1:0] z_out,
    output logic              neg_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              range_err
);

`ifdef CORDIC_GAIN_PRELOAD_EN
    localparam logic [WORD_W-1:0] X_INIT = K_GAIN;
`else
    localparam logic [WORD_W-1:0] X_INIT = ONE_Q30;
`endif

    logic signed [WORD_W-1:0] angle;
    fold_e                    kind;
    cordic_word_t             folded;
    cordic_word_t             head;
    logic [BUF_W-1:0]         headBits;
    logic                     accept;

    assign angle  = $signed(angle_in);
    assign kind   = fold_kind(angle);
    assign accept = in_valid && in_ready;

    // Legal inputs stay within [-pi, pi), so +/-pi corrections never wrap.
    always_comb begin
        folded.neg = 1'b0;
        folded.z   = angle;
        folded.y   = '0;
        folded.x   = X_INIT;
        case (kind)
            FOLD_SUB: begin
                folded.z   = angle - PI;
                folded.neg = 1'b1;
            end
            FOLD_ADD: begin
                folded.z   = angle + PI;
                folded.neg = 1'b1;
            end
            default: begin
                folded.z   = angle;
                folded.neg = 1'b0;
            end
        endcase
    end

    cordic_skid_buf #(
        .WIDTH(BUF_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .in_data  (folded),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (headBits),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    assign head    = cordic_word_t'(headBits);
    assign x_out   = head.x;
    assign y_out   = head.y;
    assign z_out   = head.z;
    assign neg_out = head.neg;

    // Out-of-range words are still forwarded; the flag only records that one was seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            range_err <= 1'b0;
        end else if (accept && (angle >= PI)) begin
            range_err <= 1'b1;
        end
    end

endmodule

// File: doc/cordic_quadrant_map.md
CORDIC_QUADRANT_MAP -- requirements
Module: cordic_quadrant_map

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port angle_in, input, 32 bits: signed angle, Q3.29 radians, legal range [-pi, pi).
REQ-004 SHALL have port in_valid, input, 1 bit: angle_in is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a word.
REQ-006 SHALL have port x_out, output, 32 bits: initial x, Q2.30.
REQ-007 SHALL have port y_out, output, 32 bits: initial y, Q2.30.
REQ-008 SHALL have port z_out, output, 32 bits: folded residual angle, Q3.29.
REQ-009 SHALL have port neg_out, output, 1 bit: downstream must negate the final x/y.
REQ-010 SHALL have port out_valid, input-side counterpart to in_valid, output, 1 bit: x/y/z/neg_out are valid.
REQ-011 SHALL have port out_ready, input, 1 bit: first rotation stage accepts the word.
REQ-012 SHALL have port range_err, output, 1 bit: sticky flag, illegal angle seen.

Function
REQ-013 SHALL complete a transfer on either side only in a cycle where valid and ready are both high.
REQ-014 Fold rule: if z > PI_2 (0x3243F6A9), SHALL output z - PI (PI = 0x6487ED51) with neg_out = 1.
REQ-015 Fold rule: if z < -PI_2 (0xCDBC0957), SHALL output z + PI with neg_out = 1.
REQ-016 Otherwise SHALL pass z unchanged with neg_out = 0; both +-PI_2 are inclusive and do not fold.
REQ-017 SHALL perform all angle arithmetic as signed 32-bit two's complement; in-range results cannot wrap.
REQ-018 SHALL drive y_out = 0 for every word.
REQ-019 SHALL drive x_out as set by REQ-030 and REQ-031.
REQ-020 SHALL present an accepted word on the outputs exactly 1 cycle after acceptance when the buffer is empty.
REQ-021 SHALL hold a 2-entry FIFO skid buffer; output word order equals input order.
REQ-022 SHALL drive in_ready as a register equal to (occupancy < 2), with no combinational path from out_ready.
REQ-023 SHALL sustain 1 word/cycle while out_ready stays high.
REQ-024 When full, SHALL hold all outputs stable until out_ready; a push and pop in the same cycle SHALL keep occupancy unchanged.
REQ-025 An input with angle_in >= PI (signed) SHALL set range_err; that word is still folded and forwarded, and range_err stays set until rst.

Reset
REQ-026 While rst is high, SHALL force occupancy 0, out_valid 0, in_ready 0 and range_err 0.
REQ-027 While rst is high, SHALL force x_out, y_out, z_out to 0 and neg_out to 0.
REQ-028 SHALL drive in_ready 1 in the first cycle after rst falls.
REQ-029 Reset mid-transfer SHALL discard buffered words; no word is emitted after reset.

Configuration
REQ-030 With CORDIC_GAIN_PRELOAD_EN defined, SHALL drive x_out = K = 0x26DD3B6B (0.6072529 in Q2.30) so the final output needs no gain correction.
REQ-031 Without CORDIC_GAIN_PRELOAD_EN, SHALL drive x_out = 0x40000000 (1.0); downstream then applies the gain.

Structure
REQ-032 SHALL take PI, PI_2, K_GAIN, ONE_Q30 and the word width from shared package cordic_pkg, which the rotation stages also use.
REQ-033 SHALL implement the buffer as one sub-module, cordic_skid_buf, parameterised on data width; it carries the 97-bit word {neg, z, y, x}.

Verification
REQ-034 Test rst held for 3 cycles then released: all outputs 0 during reset; in_ready = 1 in the first cycle after rst falls.
REQ-035 Test angle_in = 0x40000000, out_ready = 1: 1 cycle later z_out = 0xDB7812AF, neg_out = 1, y_out = 0.
REQ-036 Test the fold boundaries: 0xCDBC0957 -> z_out = 0xCDBC0957, neg_out = 0; 0x3243F6AA -> z_out = 0xCDBC0959, neg_out = 1.
REQ-037 Test 4 back-to-back inputs with out_ready = 0: in_ready falls after 2 accepts; on release the 2 buffered words emerge in order with no loss or duplicate.
REQ-038 Test angle_in = 0x6487ED51: range_err rises and stays set until the next rst.
REQ-039 Run the bench both with and without CORDIC_GAIN_PRELOAD_EN: x_out = 0x26DD3B6B and 0x40000000 respectively.
